// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared Y86-64 constants for the memory stage.
//   - NIBBLE/D_WORD field widths
//   - opcode (icode) and status codes, RNONE
//   - the M pipeline register layout and its bubble value
//   - small helpers classifying an icode as a data-memory read or write
package memory_stage_pkg;

    localparam int NIBBLE = 4;
    localparam int D_WORD = 64;

    // Opcodes
    localparam logic [NIBBLE-1:0] IHALT   = 4'h0;
    localparam logic [NIBBLE-1:0] INOP    = 4'h1;
    localparam logic [NIBBLE-1:0] IRRMOVQ = 4'h2;
    localparam logic [NIBBLE-1:0] IIRMOVQ = 4'h3;
    localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
    localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
    localparam logic [NIBBLE-1:0] IJXX    = 4'h7;
    localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
    localparam logic [NIBBLE-1:0] IRET    = 4'h9;
    localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
    localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [NIBBLE-1:0] SAOK = 4'h1;
    localparam logic [NIBBLE-1:0] SHLT = 4'h2;
    localparam logic [NIBBLE-1:0] SADR = 4'h3;
    localparam logic [NIBBLE-1:0] SINS = 4'h4;

    localparam logic [NIBBLE-1:0] RNONE = 4'hF;

    // Bytes per data-memory access
    localparam int WORD_BYTES = 8;

    typedef struct packed {
        logic [NIBBLE-1:0] stat;
        logic [NIBBLE-1:0] icode;
        logic              cnd;
        logic [D_WORD-1:0] val_e;
        logic [D_WORD-1:0] val_a;
        logic [NIBBLE-1:0] dst_e;
        logic [NIBBLE-1:0] dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    function automatic logic is_mem_read(input logic [NIBBLE-1:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
    endfunction

    function automatic logic is_mem_write(input logic [NIBBLE-1:0] icode);
        return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
    endfunction

    // Stack pops and returns address memory through valA (the old %rsp);
    // every other access uses the ALU result.
    function automatic logic uses_val_a_addr(input logic [NIBBLE-1:0] icode);
        return (icode == IPOPQ) || (icode == IRET);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: groups the execute-side inputs, the pipeline-control
// inputs (M_bubble_i, W_stat_i) and the M-register / memory-stage outputs.
//   master: the pipeline surroundings (drives E-side values, sees M outputs)
//   slave : memory_stage itself
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic [NIBBLE-1:0] E_stat_i;
    logic [NIBBLE-1:0] E_icode_i;
    logic              e_Cnd_i;
    logic [D_WORD-1:0] e_valE_i;
    logic [D_WORD-1:0] E_valA_i;
    logic [NIBBLE-1:0] e_dstE_i;
    logic [NIBBLE-1:0] E_dstM_i;
    logic              M_bubble_i;
    logic [NIBBLE-1:0] W_stat_i;

    logic [NIBBLE-1:0] M_stat_o;
    logic [NIBBLE-1:0] M_icode_o;
    logic [NIBBLE-1:0] M_dstE_o;
    logic [NIBBLE-1:0] M_dstM_o;
    logic              M_Cnd_o;
    logic [D_WORD-1:0] M_valE_o;
    logic [D_WORD-1:0] M_valA_o;
    logic [NIBBLE-1:0] m_stat_o;
    logic [D_WORD-1:0] m_valM_o;

    modport master (
        output E_stat_i, E_icode_i, e_Cnd_i, e_valE_i, E_valA_i, e_dstE_i, E_dstM_i,
               M_bubble_i, W_stat_i,
        input  M_stat_o, M_icode_o, M_dstE_o, M_dstM_o, M_Cnd_o, M_valE_o, M_valA_o,
               m_stat_o, m_valM_o
    );

    modport slave (
        input  E_stat_i, E_icode_i, e_Cnd_i, e_valE_i, E_valA_i, e_dstE_i, E_dstM_i,
               M_bubble_i, W_stat_i,
        output M_stat_o, M_icode_o, M_dstE_o, M_dstM_o, M_Cnd_o, M_valE_o, M_valA_o,
               m_stat_o, m_valM_o
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// data_mem: byte-addressable data memory, MEM_BYTES bytes.
//   clk_i : clock
//   we    : write 8 bytes of wdata at addr on the rising edge
//   addr  : byte address (caller guarantees addr+7 is in range when writing)
//   wdata : store data, little-endian
//   rdata : combinational 8-byte little-endian read at addr
// Contents are never cleared; bounds checking is done by the caller.
module data_mem #(
    parameter  int MEM_BYTES = 4096,
    localparam int AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                mem[addr + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    // Bytes past the end read as zero so an out-of-range lookup never
    // indexes outside the array; the caller masks such reads anyway.
    always_comb begin
        logic [AW:0] idx;
        rdata = '0;
        idx   = '0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, addr} + (AW+1)'(k);
            if (int'(idx) < MEM_BYTES) begin
                rdata[8*k +: 8] = mem[idx[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 memory stage.
//   clk_i : clock, all state on the rising edge
//   rst_i : synchronous active-high reset (loads a bubble into M)
//   bus   : memory_stage_if.slave
//           in : E_stat/E_icode/e_Cnd/e_valE/E_valA/e_dstE/E_dstM, M_bubble, W_stat
//           out: M_* register fields, m_stat (status), m_valM (load data)
// Holds the M pipeline register, performs the single 8-byte load or store
// of the instruction in M, and reports an address error as SADR.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic            clk_i,
    input  logic            rst_i,
    memory_stage_if.slave   bus
);

    localparam int          AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    // Highest address at which a full 8-byte word still fits.
    localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - WORD_BYTES);

    m_reg_t      m_q;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic        dmem_error;
    logic        mem_we;
    logic [63:0] rdata;

    // M register: never holds; reset wins over bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.M_bubble_i) begin
            m_q <= M_BUBBLE;
        end else begin
            m_q.stat  <= bus.E_stat_i;
            m_q.icode <= bus.E_icode_i;
            m_q.cnd   <= bus.e_Cnd_i;
            m_q.val_e <= bus.e_valE_i;
            m_q.val_a <= bus.E_valA_i;
            m_q.dst_e <= bus.e_dstE_i;
            m_q.dst_m <= bus.E_dstM_i;
        end
    end

    assign mem_rd   = is_mem_read(m_q.icode);
    assign mem_wr   = is_mem_write(m_q.icode);
    assign mem_addr = uses_val_a_addr(m_q.icode) ? m_q.val_a : m_q.val_e;

    // Unsigned compare: negative addresses look huge and fail here.
    assign dmem_error = (mem_rd || mem_wr) && (mem_addr > LAST_OK);

    // Depends only on the current M contents, so a store sitting in M
    // still commits on the edge where reset squashes M.
    assign mem_we = mem_wr && (m_q.stat == SAOK) && !dmem_error && (bus.W_stat_i == SAOK);

    data_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_data_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .addr  (mem_addr[AW-1:0]),
        .wdata (m_q.val_a),
        .rdata (rdata)
    );

    assign bus.M_stat_o  = m_q.stat;
    assign bus.M_icode_o = m_q.icode;
    assign bus.M_Cnd_o   = m_q.cnd;
    assign bus.M_valE_o  = m_q.val_e;
    assign bus.M_valA_o  = m_q.val_a;
    assign bus.M_dstE_o  = m_q.dst_e;
    assign bus.M_dstM_o  = m_q.dst_m;

    assign bus.m_stat_o  = dmem_error ? SADR : m_q.stat;
    assign bus.m_valM_o  = (mem_rd && !dmem_error) ? rdata : '0;

endmodule
